// File: rtl/fetch_pipe_if.sv
// Bus between the fetch stage and its neighbours: hazard/branch controls in,
// instruction memory word in, fetch PC and IF/ID pipeline register contents out.
interface fetch_pipe_if;
   // stop freezes PC and IF/ID for as many cycles as it is held; br_taken is
   // only honoured in a cycle where stop is low.
   logic        stop;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] instr_IF;
   logic [31:0] pc_IF;
   logic [31:0] ins_ID;
   logic [31:0] pc4_ID;
   logic [31:0] pc8_ID;
   logic [31:0] stall_cnt;

   modport master (
      output stop, br_taken, br_target, instr_IF,
      input  pc_IF, ins_ID, pc4_ID, pc8_ID, stall_cnt
   );

   modport slave (
      input  stop, br_taken, br_target, instr_IF,
      output pc_IF, ins_ID, pc4_ID, pc8_ID, stall_cnt
   );
endinterface

// File: rtl/fetch_pipe.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a stall
// counter. Branches redirect the PC without flushing the delay slot.
module fetch_pipe #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic         clk,
   input  logic         reset,
   fetch_pipe_if.slave  bus
);

   logic [31:0] pc_q,    pc_d;
   logic [31:0] ins_q,   ins_d;
   logic [31:0] pc4_q,   pc4_d;
   logic [31:0] stall_q, stall_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d    = pc_q;
      ins_d   = ins_q;
      pc4_d   = pc4_q;
      stall_d = stall_q;
      if (bus.stop) begin
         stall_d = stall_q + 32'd1;
      end else begin
         // The word fetched in the redirect cycle is the delay slot and still
         // moves into ID.
         ins_d = bus.instr_IF;
         pc4_d = pc_plus4;
         if (bus.br_taken) begin
            pc_d = {bus.br_target[31:2], 2'b00};
         end else begin
            pc_d = pc_plus4;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         ins_q   <= 32'd0;
         pc4_q   <= 32'd0;
         stall_q <= 32'd0;
      end else begin
         pc_q    <= pc_d;
         ins_q   <= ins_d;
         pc4_q   <= pc4_d;
         stall_q <= stall_d;
      end
   end

   assign bus.pc_IF     = pc_q;
   assign bus.ins_ID    = ins_q;
   assign bus.pc4_ID    = pc4_q;
   assign bus.pc8_ID    = pc4_q + 32'd4;
   assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_fetch_pipe.sv
// Bench for fetch_pipe: directed vector table, a wrap-around sequence on a
// second instance, and randomized cycles against a rule-level model.
module tb_fetch_pipe;

   logic clk;
   logic rst1;
   logic rst2;
   int   n_cmp;
   int   n_err;

   fetch_pipe_if bus1 ();
   fetch_pipe_if bus2 ();

   fetch_pipe #(.RESET_PC(32'h0000_3000)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));
   fetch_pipe #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .reset(rst2), .bus(bus2));

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return a ^ 32'hDEAD_0000 ^ {a[7:0], 24'h0};
   endfunction

   assign bus1.instr_IF = imem(bus1.pc_IF);
   assign bus2.instr_IF = imem(bus2.pc_IF);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // driver: apply inputs, clock once, settle after the edge
   task automatic step1(input logic r, input logic s, input logic b, input logic [31:0] t);
      rst1 = r;
      bus1.stop = s;
      bus1.br_taken = b;
      bus1.br_target = t;
      @(posedge clk);
      #1;
   endtask

   task automatic step2(input logic r, input logic s, input logic b, input logic [31:0] t);
      rst2 = r;
      bus2.stop = s;
      bus2.br_taken = b;
      bus2.br_target = t;
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] pc4, input logic [31:0] st);
      chk({tag, ".pc_IF"},     bus1.pc_IF,     pc);
      chk({tag, ".ins_ID"},    bus1.ins_ID,    ins);
      chk({tag, ".pc4_ID"},    bus1.pc4_ID,    pc4);
      chk({tag, ".pc8_ID"},    bus1.pc8_ID,    pc4 + 32'd4);
      chk({tag, ".stall_cnt"}, bus1.stall_cnt, st);
   endtask

   typedef struct {
      logic        r, s, b;
      logic [31:0] tgt;
      logic [31:0] pc, ins, pc4, st;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [31:0] tgt,
                               input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] pc4, input logic [31:0] st);
      vec_t v;
      v.r = r; v.s = s; v.b = b; v.tgt = tgt;
      v.pc = pc; v.ins = ins; v.pc4 = pc4; v.st = st;
      return v;
   endfunction

   // behavioural model state
   logic [31:0] m_pc, m_ins, m_pc4, m_st;

   task automatic rand_cycle(input int idx);
      logic r, s, b;
      logic [31:0] t;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 9) < 3);
      b = ($urandom_range(0, 9) < 2);
      t = $urandom;
      if (r) begin
         m_pc = 32'h3000; m_ins = 0; m_pc4 = 0; m_st = 0;
      end else if (s) begin
         m_st = m_st + 1;
      end else begin
         m_ins = imem(m_pc);
         m_pc4 = m_pc + 4;
         m_pc  = b ? (t & 32'hFFFF_FFFC) : m_pc + 4;
      end
      step1(r, s, b, t);
      chk1($sformatf("rand%0d", idx), m_pc, m_ins, m_pc4, m_st);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst1 = 1'b1; rst2 = 1'b1;
      bus1.stop = 0; bus1.br_taken = 0; bus1.br_target = 0;
      bus2.stop = 0; bus2.br_taken = 0; bus2.br_target = 0;

      vecs[0]  = mk(1,0,0,0,           32'h3000, 0,              0,        0);
      vecs[1]  = mk(0,0,0,0,           32'h3004, imem(32'h3000), 32'h3004, 0);
      vecs[2]  = mk(0,0,0,0,           32'h3008, imem(32'h3004), 32'h3008, 0);
      vecs[3]  = mk(0,1,0,0,           32'h3008, imem(32'h3004), 32'h3008, 1);
      vecs[4]  = mk(0,1,0,0,           32'h3008, imem(32'h3004), 32'h3008, 2);
      vecs[5]  = mk(0,0,0,0,           32'h300C, imem(32'h3008), 32'h300C, 2);
      vecs[6]  = mk(1,0,0,0,           32'h3000, 0,              0,        0);
      vecs[7]  = mk(0,0,0,0,           32'h3004, imem(32'h3000), 32'h3004, 0);
      vecs[8]  = mk(0,0,0,0,           32'h3008, imem(32'h3004), 32'h3008, 0);
      vecs[9]  = mk(0,0,1,32'h3040,    32'h3040, imem(32'h3008), 32'h300C, 0);
      vecs[10] = mk(0,0,0,0,           32'h3044, imem(32'h3040), 32'h3044, 0);
      vecs[11] = mk(0,1,1,32'h3100,    32'h3044, imem(32'h3040), 32'h3044, 1);
      vecs[12] = mk(0,0,1,32'h3100,    32'h3100, imem(32'h3044), 32'h3048, 1);
      vecs[13] = mk(0,0,1,32'h3043,    32'h3040, imem(32'h3100), 32'h3104, 1);
      vecs[14] = mk(0,1,0,0,           32'h3040, imem(32'h3100), 32'h3104, 2);
      vecs[15] = mk(1,1,1,32'h5000,    32'h3000, 0,              0,        0);
      vecs[16] = mk(0,0,0,0,           32'h3004, imem(32'h3000), 32'h3004, 0);

      for (int i = 0; i < 17; i++) begin
         step1(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].tgt);
         chk1($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ins, vecs[i].pc4, vecs[i].st);
      end

      // wrap-around on the instance reset to the top of the address space
      step2(1, 0, 0, 0);
      chk("wrap.reset_pc", bus2.pc_IF, 32'hFFFF_FFFC);
      chk("wrap.reset_pc8", bus2.pc8_ID, 32'd4);
      step2(0, 0, 0, 0);
      chk("wrap.pc_zero", bus2.pc_IF, 32'd0);
      chk("wrap.pc4_zero", bus2.pc4_ID, 32'd0);
      chk("wrap.ins", bus2.ins_ID, imem(32'hFFFF_FFFC));
      step2(0, 0, 1, 32'hFFFF_FFFA);
      chk("wrap.br_align", bus2.pc_IF, 32'hFFFF_FFF8);
      step2(0, 0, 0, 0);
      chk("wrap.pc4_top", bus2.pc4_ID, 32'hFFFF_FFFC);
      chk("wrap.pc8_wrap", bus2.pc8_ID, 32'd0);

      // randomized run against the model, starting from a reset
      m_pc = 32'h3000; m_ins = 0; m_pc4 = 0; m_st = 0;
      step1(1, 0, 0, 0);
      chk1("rand_reset", m_pc, m_ins, m_pc4, m_st);
      for (int i = 0; i < 400; i++) rand_cycle(i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_pipe.md
FETCH_PIPE -- requirements
Module: fetch_pipe

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have port stop  input  1  hazard-unit stall request; freezes PC and IF/ID.
REQ-005 SHALL have port br_taken  input  1  ID-stage branch/jump redirect request.
REQ-006 SHALL have port br_target  input  32  redirect address from ID stage.
REQ-007 SHALL have port instr_IF  input  32  instruction word returned combinationally by instruction memory for pc_IF.
REQ-008 SHALL have port pc_IF  output  32  current fetch PC, drives instruction-memory address.
REQ-009 SHALL have port ins_ID  output  32  IF/ID register: instruction in decode.
REQ-010 SHALL have port pc4_ID  output  32  IF/ID register: PC+4 of the decode instruction.
REQ-011 SHALL have port pc8_ID  output  32  pc4_ID+4, link address for jal/jalr.
REQ-012 SHALL have port stall_cnt  output  32  count of stalled cycles since reset.

Function
REQ-013 SHALL update the PC with priority reset > stop > br_taken > sequential.
REQ-014 SHALL load RESET_PC into the PC on reset.
REQ-015 SHALL hold the PC unchanged while stop=1 and reset=0.
REQ-016 SHALL load {br_target[31:2],2'b00} when br_taken=1 and stop=0.
REQ-017 SHALL load pc_IF+4 (mod 2^32, wrap at 32'hFFFF_FFFC -> 0) otherwise.
REQ-018 SHALL clear ins_ID and pc4_ID to 0 on reset (ins_ID=0 decodes as nop).
REQ-019 SHALL hold ins_ID and pc4_ID while stop=1.
REQ-020 SHALL capture ins_ID<=instr_IF and pc4_ID<=pc_IF+4 otherwise.
REQ-021 SHALL NOT flush IF/ID on br_taken: the delay-slot instruction fetched in the redirect cycle enters ID next cycle.
REQ-022 SHALL drive pc8_ID combinationally as pc4_ID+4, mod 2^32.
REQ-023 SHALL ignore br_taken in any cycle with stop=1, redirect occurring in the first cycle the held ID instruction sees stop=0.
REQ-024 SHALL hold state for any number of consecutive stop cycles with no internal limit.
REQ-025 SHALL increment stall_cnt by 1 each cycle stop=1 and reset=0, wrapping 32'hFFFF_FFFF -> 0.
REQ-026 SHALL have no combinational path from stop, br_taken or br_target to any output; all outputs are registered except pc8_ID.
REQ-027 SHALL contain no initial blocks; reset alone defines state.

Reset
REQ-028 SHALL, in the cycle after reset sampled high: pc_IF=RESET_PC, ins_ID=0, pc4_ID=0, pc8_ID=4, stall_cnt=0.
REQ-029 SHALL give reset priority over stop and br_taken in the same cycle, including reset asserted mid-stall.
REQ-030 SHALL fetch from RESET_PC in the first cycle after reset deasserts.

Verification
REQ-031 SHALL check sequential fetch: reset, then 3 cycles with stop=0 -> pc_IF 3000,3004,3008,300C; ins_ID lags instr_IF by one cycle; pc4_ID=3004 when ins_ID holds word from 3000.
REQ-032 SHALL check stall: stop=1 for 2 cycles with pc_IF=3008 -> pc_IF stays 3008, ins_ID/pc4_ID unchanged, stall_cnt 0->2; next cycle pc_IF=300C.
REQ-033 SHALL check branch with delay slot: branch at 3004 in ID, br_taken=1, br_target=3040 -> next pc_IF=3040, ins_ID=word from 3008 (not flushed).
REQ-034 SHALL check stall-vs-branch: stop=1 and br_taken=1 together -> PC held; next cycle stop=0, br_taken=1 -> pc_IF=br_target.
REQ-035 SHALL check reset mid-stall: stop=1, reset=1 -> pc_IF=3000, ins_ID=0, stall_cnt=0 next cycle.
REQ-036 SHALL check wrap and alignment: RESET_PC=32'hFFFF_FFFC -> next pc_IF=0, pc8_ID wraps; br_target=3043 -> pc_IF=3040.
